// File: rtl/frame_wr_scheduler.sv
// frame_wr_scheduler
//   Merges two write sources into one registered frame-buffer write port.
//   The CPU path is buffered in a small in-order FIFO. The accelerator (XL)
//   path is unbuffered and normally wins arbitration. A streak counter stops
//   the accelerator from starving the CPU: once MAX_XL_STREAK XL grants have
//   gone by while CPU data waits, the FIFO head is forced out.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   cpu_wr_valid/ready/data/addr  CPU write request (into FIFO)
//   xl_wr_valid/ready/data/addr   accelerator write request (direct)
//   frame_wr_en/data/addr         registered frame buffer write port
//   cpu_fifo_count                CPU FIFO occupancy
module frame_wr_scheduler #(
  parameter int mem_width      = 32,
  parameter int mem_depth      = 32,
  parameter int mem_addr_width = $clog2(mem_depth),
  parameter int CPU_FIFO_DEPTH = 4,
  parameter int MAX_XL_STREAK  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cpu_wr_valid,
  output logic                             cpu_wr_ready,
  input  logic [mem_width-1:0]             cpu_wr_data,
  input  logic [mem_addr_width-1:0]        cpu_wr_addr,
  input  logic                             xl_wr_valid,
  output logic                             xl_wr_ready,
  input  logic [mem_width-1:0]             xl_wr_data,
  input  logic [mem_addr_width-1:0]        xl_wr_addr,
  output logic                             frame_wr_en,
  output logic [mem_width-1:0]             frame_wr_data,
  output logic [mem_addr_width-1:0]        frame_wr_addr,
  output logic [$clog2(CPU_FIFO_DEPTH):0]  cpu_fifo_count
);

  localparam int PTR_W = $clog2(CPU_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STK_W = $clog2(MAX_XL_STREAK + 1);

  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(CPU_FIFO_DEPTH);
  localparam logic [STK_W-1:0] STREAK_MAX = STK_W'(MAX_XL_STREAK);

  typedef struct packed {
    logic [mem_addr_width-1:0] addr;
    logic [mem_width-1:0]      data;
  } wr_req_t;

  // ---------------------------------------------------------------------
  // CPU FIFO
  // ---------------------------------------------------------------------
  wr_req_t          fifo_mem [CPU_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  wr_req_t cpu_req, xl_req, head;
  logic    push, pop;

  assign cpu_req = '{addr: cpu_wr_addr, data: cpu_wr_data};
  assign xl_req  = '{addr: xl_wr_addr,  data: xl_wr_data};
  assign head    = fifo_mem[rd_ptr];

  // Ready looks only at the registered count, so a full FIFO refuses a
  // push even in a cycle where it is also being popped.
  assign cpu_wr_ready   = (count < FIFO_FULL);
  assign push           = cpu_wr_valid && cpu_wr_ready;
  assign cpu_fifo_count = count;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage needs no reset: occupancy is tracked by count alone, so
  // clearing the pointers and count discards every buffered entry.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cpu_req;
  end

  // Depth is a power of two, so pointer increment wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [STK_W-1:0] streak, streak_nxt;
  logic             pend, force_cpu, grant_cpu, grant_xl;

  // pend is taken from the registered count, so an entry pushed this cycle
  // is never eligible until the next one.
  assign pend      = (count != '0);
  assign force_cpu = pend && (streak == STREAK_MAX);
  assign grant_cpu = pend && (force_cpu || !xl_wr_valid);
  assign grant_xl  = xl_wr_valid && !grant_cpu;
  assign pop       = grant_cpu;

  // XL is only held off when the CPU is forced; otherwise a valid XL
  // request is always granted, so ready&valid coincides with grant_xl.
  assign xl_wr_ready = !force_cpu;

  // Streak counts XL grants taken while the CPU is waiting.
  always_comb begin
    streak_nxt = streak;
    if (!pend || grant_cpu)
      streak_nxt = '0;
    else if (grant_xl && (streak != STREAK_MAX))
      streak_nxt = streak + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak <= '0;
    else     streak <= streak_nxt;
  end

  // ---------------------------------------------------------------------
  // Registered frame write port; addr/data hold when idle
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_wr_en   <= 1'b0;
      frame_wr_data <= '0;
      frame_wr_addr <= '0;
    end else begin
      frame_wr_en <= grant_cpu || grant_xl;
      if (grant_cpu) begin
        frame_wr_addr <= head.addr;
        frame_wr_data <= head.data;
      end else if (grant_xl) begin
        frame_wr_addr <= xl_req.addr;
        frame_wr_data <= xl_req.data;
      end
    end
  end

endmodule

// File: tb/tb_frame_wr_scheduler.sv
module tb_frame_wr_scheduler;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk, rst;
  logic          cpu_wr_valid, cpu_wr_ready;
  logic [DW-1:0] cpu_wr_data;
  logic [AW-1:0] cpu_wr_addr;
  logic          xl_wr_valid, xl_wr_ready;
  logic [DW-1:0] xl_wr_data;
  logic [AW-1:0] xl_wr_addr;
  logic          frame_wr_en;
  logic [DW-1:0] frame_wr_data;
  logic [AW-1:0] frame_wr_addr;
  logic [2:0]    cpu_fifo_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] obs_addr [$];
  logic [DW-1:0] obs_data [$];

  frame_wr_scheduler dut (
    .clk(clk), .rst(rst),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_data(cpu_wr_data), .cpu_wr_addr(cpu_wr_addr),
    .xl_wr_valid(xl_wr_valid), .xl_wr_ready(xl_wr_ready),
    .xl_wr_data(xl_wr_data), .xl_wr_addr(xl_wr_addr),
    .frame_wr_en(frame_wr_en), .frame_wr_data(frame_wr_data),
    .frame_wr_addr(frame_wr_addr), .cpu_fifo_count(cpu_fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  // Record every frame write, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst && frame_wr_en) begin
      obs_addr.push_back(frame_wr_addr);
      obs_data.push_back(frame_wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_wr_valid = 1'b0; cpu_wr_data = '0; cpu_wr_addr = '0;
    xl_wr_valid  = 1'b0; xl_wr_data  = '0; xl_wr_addr  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    obs_addr.delete();
    obs_data.delete();
  endtask

  function automatic logic [37:0] frame_now();
    return {frame_wr_en, frame_wr_addr, frame_wr_data};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #12;
    n_cmp++;
    if (frame_now() !== 38'd0) begin
      n_bad++; $display("FAIL reset_frame: got %h want 0", frame_now());
    end
    n_cmp++;
    if ({cpu_fifo_count, cpu_wr_ready, xl_wr_ready} !== {3'd0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_ctrl: got cnt=%0d crdy=%0b xrdy=%0b want 0 1 1",
               cpu_fifo_count, cpu_wr_ready, xl_wr_ready);
    end
    do_reset();
  endtask

  task automatic test_xl_only();
    do_reset();
    xl_wr_valid = 1'b1; xl_wr_addr = 5'd5; xl_wr_data = 32'hA5;
    #1;
    n_cmp++;
    if (xl_wr_ready !== 1'b1) begin
      n_bad++; $display("FAIL xl_only_ready: got %0b want 1", xl_wr_ready);
    end
    tick();
    xl_wr_valid = 1'b0;
    n_cmp++;
    if (frame_now() !== {1'b1, 5'd5, 32'hA5}) begin
      n_bad++; $display("FAIL xl_only_out: got %h want %h", frame_now(), {1'b1, 5'd5, 32'hA5});
    end
    tick();
    n_cmp++;
    if (frame_now() !== {1'b0, 5'd5, 32'hA5}) begin
      n_bad++; $display("FAIL xl_only_idle: got %h want %h", frame_now(), {1'b0, 5'd5, 32'hA5});
    end
  endtask

  // Three back-to-back CPU pushes; the middle cycles push and pop at once.
  task automatic test_cpu_only();
    logic        exp_en  [5] = '{0, 1, 1, 1, 0};
    logic [4:0]  exp_a   [5] = '{0, 1, 2, 3, 3};
    logic [31:0] exp_d   [5] = '{0, 32'h11, 32'h22, 32'h33, 32'h33};
    logic [2:0]  exp_cnt [5] = '{1, 1, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cpu_wr_valid = (i < 3);
      cpu_wr_addr  = AW'(i + 1);
      cpu_wr_data  = 32'(8'h11 * (i + 1));
      tick();
      n_cmp++;
      if (frame_now() !== {exp_en[i], exp_a[i], exp_d[i]}) begin
        n_bad++;
        $display("FAIL cpu_only_out[%0d]: got %h want %h", i, frame_now(),
                 {exp_en[i], exp_a[i], exp_d[i]});
      end
      n_cmp++;
      if (cpu_fifo_count !== exp_cnt[i]) begin
        n_bad++;
        $display("FAIL cpu_only_cnt[%0d]: got %0d want %0d", i, cpu_fifo_count, exp_cnt[i]);
      end
    end
  endtask

  // One CPU entry against a continuous XL stream.
  task automatic test_starvation();
    logic exp_rdy [7] = '{1, 1, 1, 1, 1, 0, 1};
    int xn = 0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      cpu_wr_valid = (c == 0); cpu_wr_addr = 5'd7; cpu_wr_data = 32'h77;
      xl_wr_valid  = 1'b1;
      xl_wr_addr   = AW'(16 + xn);
      xl_wr_data   = 32'(32'h100 + xn);
      #1;
      n_cmp++;
      if (xl_wr_ready !== exp_rdy[c]) begin
        n_bad++; $display("FAIL starve_xrdy[%0d]: got %0b want %0b", c, xl_wr_ready, exp_rdy[c]);
      end
      tick();
      n_cmp++;
      if (exp_rdy[c]) begin
        if (frame_now() !== {1'b1, 5'(16 + xn), 32'(32'h100 + xn)}) begin
          n_bad++; $display("FAIL starve_xl[%0d]: got %h want xl#%0d", c, frame_now(), xn);
        end
        xn++;
      end else begin
        if (frame_now() !== {1'b1, 5'd7, 32'h77}) begin
          n_bad++; $display("FAIL starve_cpu[%0d]: got %h want %h", c, frame_now(), {1'b1, 5'd7, 32'h77});
        end
      end
    end
    idle_inputs();
    tick();
    n_cmp++;
    if (cpu_fifo_count !== 3'd0) begin
      n_bad++; $display("FAIL starve_cnt: got %0d want 0", cpu_fifo_count);
    end
  endtask

  // Fill the FIFO under XL pressure, then drain.
  task automatic test_full();
    logic [2:0] exp_cnt [11] = '{1, 2, 3, 4, 4, 3, 4, 3, 2, 1, 0};
    logic       exp_src [11] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 1};
    int xn = 0;
    int cn = 0;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      cpu_wr_valid = (c < 7);
      cpu_wr_addr  = AW'(10 + ((c < 4) ? c : 4));
      cpu_wr_data  = 32'(32'h40 + ((c < 4) ? c : 4));
      xl_wr_valid  = (c < 7);
      xl_wr_addr   = AW'(20 + xn);
      xl_wr_data   = 32'(32'h200 + xn);
      #1;
      if (c == 4 || c == 5) begin
        n_cmp++;
        if (cpu_wr_ready !== 1'b0) begin
          n_bad++; $display("FAIL full_crdy[%0d]: got %0b want 0", c, cpu_wr_ready);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (xl_wr_ready !== 1'b0) begin
          n_bad++; $display("FAIL full_xrdy: got %0b want 0", xl_wr_ready);
        end
      end
      if (c == 6) begin
        n_cmp++;
        if (cpu_wr_ready !== 1'b1) begin
          n_bad++; $display("FAIL full_crdy_reopen: got %0b want 1", cpu_wr_ready);
        end
      end
      tick();
      n_cmp++;
      if (cpu_fifo_count !== exp_cnt[c]) begin
        n_bad++; $display("FAIL full_cnt[%0d]: got %0d want %0d", c, cpu_fifo_count, exp_cnt[c]);
      end
      n_cmp++;
      if (exp_src[c]) begin
        if (frame_now() !== {1'b1, 5'(10 + cn), 32'(32'h40 + cn)}) begin
          n_bad++; $display("FAIL full_cpu[%0d]: got %h want cpu#%0d", c, frame_now(), cn);
        end
        cn++;
      end else begin
        if (frame_now() !== {1'b1, 5'(20 + xn), 32'(32'h200 + xn)}) begin
          n_bad++; $display("FAIL full_xl[%0d]: got %h want xl#%0d", c, frame_now(), xn);
        end
        xn++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      cpu_wr_valid = 1'b1; cpu_wr_addr = AW'(1 + c); cpu_wr_data = 32'(32'hF1 + c);
      xl_wr_valid  = 1'b1; xl_wr_addr  = 5'd25;      xl_wr_data  = 32'h300;
      tick();
    end
    idle_inputs();
    n_cmp++;
    if (cpu_fifo_count !== 3'd3) begin
      n_bad++; $display("FAIL midrst_fill: got %0d want 3", cpu_fifo_count);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({cpu_fifo_count, frame_wr_en, cpu_wr_ready, xl_wr_ready} !== {3'd0, 1'b0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL midrst_async: got cnt=%0d en=%0b crdy=%0b xrdy=%0b want 0 0 1 1",
               cpu_fifo_count, frame_wr_en, cpu_wr_ready, xl_wr_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    obs_addr.delete();
    obs_data.delete();
    repeat (4) tick();
    n_cmp++;
    if (obs_addr.size() !== 0) begin
      n_bad++; $display("FAIL midrst_leak: got %0d writes want 0", obs_addr.size());
    end
    cpu_wr_valid = 1'b1; cpu_wr_addr = 5'd30; cpu_wr_data = 32'hBEEF;
    tick();
    idle_inputs();
    tick();
    n_cmp++;
    if (frame_now() !== {1'b1, 5'd30, 32'hBEEF}) begin
      n_bad++; $display("FAIL midrst_new: got %h want %h", frame_now(), {1'b1, 5'd30, 32'hBEEF});
    end
    tick();
    n_cmp++;
    if (obs_addr.size() !== 1) begin
      n_bad++; $display("FAIL midrst_once: got %0d writes want 1", obs_addr.size());
    end
  endtask

  // Ten CPU writes wrap the pointers while XL requests arrive at random.
  task automatic test_wrap();
    int ci = 0;
    int xh = 0;
    int cyc = 0;
    int cpu_seen = 0;
    int xl_seen = 0;
    do_reset();
    while (ci < 10 && cyc < 300) begin
      cpu_wr_valid = 1'b1;
      cpu_wr_addr  = AW'(ci);
      cpu_wr_data  = 32'(32'hC00 + ci);
      xl_wr_valid  = 1'($urandom_range(0, 1));
      xl_wr_addr   = AW'(24 + (xh % 8));
      xl_wr_data   = 32'(32'hD00 + xh);
      #1;
      if (cpu_wr_ready) ci++;
      if (xl_wr_valid && xl_wr_ready) xh++;
      tick();
      cyc++;
    end
    idle_inputs();
    n_cmp++;
    if (ci !== 10) begin
      n_bad++; $display("FAIL wrap_timeout: got %0d accepted want 10", ci);
    end
    repeat (12) tick();
    for (int k = 0; k < obs_addr.size(); k++) begin
      if (obs_addr[k] < 5'd24) begin
        n_cmp++;
        if ({obs_addr[k], obs_data[k]} !== {5'(cpu_seen), 32'(32'hC00 + cpu_seen)}) begin
          n_bad++;
          $display("FAIL wrap_cpu_order[%0d]: got a=%0d d=%h want a=%0d", k, obs_addr[k], obs_data[k], cpu_seen);
        end
        cpu_seen++;
      end else begin
        n_cmp++;
        if (obs_data[k] !== 32'(32'hD00 + xl_seen)) begin
          n_bad++; $display("FAIL wrap_xl_order[%0d]: got %h want %h", k, obs_data[k], 32'(32'hD00 + xl_seen));
        end
        xl_seen++;
      end
    end
    n_cmp++;
    if (cpu_seen !== 10) begin
      n_bad++; $display("FAIL wrap_cpu_total: got %0d want 10", cpu_seen);
    end
    n_cmp++;
    if (xl_seen !== xh) begin
      n_bad++; $display("FAIL wrap_xl_total: got %0d want %0d", xl_seen, xh);
    end
  endtask

  initial begin
    test_reset();
    test_xl_only();
    test_cpu_only();
    test_starvation();
    test_full();
    test_reset_midflight();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_wr_scheduler.md
FRAME_WR_SCHEDULER -- requirements
Module: frame_wr_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- mem_width, 32, frame word width
- mem_depth, 32, frame buffer depth
- mem_addr_width, log2(mem_depth), address width
- CPU_FIFO_DEPTH, 4, CPU write buffer entries (power of 2, >=2)
- MAX_XL_STREAK, 4, consecutive XL grants allowed while CPU data is pending (>=1)
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- rst, in, 1, asynchronous active-high reset
- cpu_wr_valid, in, 1, CPU write request
- cpu_wr_ready, out, 1, CPU write accepted when valid&ready
- cpu_wr_data, in, mem_width, CPU write data
- cpu_wr_addr, in, mem_addr_width, CPU write address
- xl_wr_valid, in, 1, accelerator (XL) write request
- xl_wr_ready, out, 1, XL write accepted when valid&ready
- xl_wr_data, in, mem_width, XL write data
- xl_wr_addr, in, mem_addr_width, XL write address
- frame_wr_en, out, 1, registered frame buffer write enable
- frame_wr_data, out, mem_width, registered write data
- frame_wr_addr, out, mem_addr_width, registered write address
- cpu_fifo_count, out, log2(CPU_FIFO_DEPTH)+1, CPU FIFO occupancy
REQ-003 The block SHALL use the single clock clk; rst SHALL be asynchronous and active-high.

Function
REQ-004 CPU writes SHALL be pushed into an in-order FIFO; cpu_wr_ready SHALL be 1 iff cpu_fifo_count < CPU_FIFO_DEPTH, with no same-cycle bypass when full, even if a pop occurs.
REQ-005 A CPU handshake at edge k SHALL make the entry eligible for grant in the cycle after edge k; the FIFO SHALL never drive the output in the push cycle.
REQ-006 Each cycle, let pend = (cpu_fifo_count != 0) and force = pend && (streak == MAX_XL_STREAK).
REQ-007 Grant rule: CPU if pend && (force || !xl_wr_valid); else XL if xl_wr_valid; else none.
REQ-008 xl_wr_ready SHALL equal !force, combinationally; an XL handshake SHALL occur iff XL is granted.
REQ-009 On a grant, the granted addr/data SHALL be registered onto frame_wr_addr/frame_wr_data with frame_wr_en=1 at the next edge (1-cycle latency); with no grant, frame_wr_en SHALL be 0 and data/addr SHALL hold their previous value.
REQ-010 A CPU grant SHALL pop the FIFO head at the same edge; a simultaneous push and pop SHALL leave the count unchanged.
REQ-011 streak (0..MAX_XL_STREAK) SHALL increment, saturating, on an XL grant while pend=1; it SHALL clear to 0 on a CPU grant or in any cycle with pend=0.
REQ-012 Read and write pointers SHALL wrap modulo CPU_FIFO_DEPTH; count SHALL never exceed CPU_FIFO_DEPTH or underflow.
REQ-013 CPU writes SHALL reach the frame outputs in acceptance order, each exactly once; XL writes SHALL never be dropped or duplicated.

Reset
REQ-014 While rst=1: FIFO empty, count=0, streak=0, frame_wr_en=0, frame_wr_data=0, frame_wr_addr=0, cpu_wr_ready=1, xl_wr_ready=1; no handshake SHALL be recorded.
REQ-015 rst asserted mid-operation SHALL discard all buffered CPU writes; the first grant after release SHALL come only from requests presented after release.

Verification
REQ-016 XL only: xl_wr_valid=1, addr=5, data=0xA5 for 1 cycle -> next cycle frame_wr_en=1, addr=5, data=0xA5; the following cycle frame_wr_en=0.
REQ-017 CPU only: push addr 1..3, data 0x11,0x22,0x33 on consecutive cycles -> frame writes addr 1,2,3 on cycles k+2..k+4, in order.
REQ-018 Starvation: 1 CPU entry pending, xl_wr_valid held at 1 -> 4 XL writes, then xl_wr_ready=0 for 1 cycle and the CPU write is output, then XL resumes with streak=0.
REQ-019 Full: 4 CPU pushes with xl_wr_valid=1 -> cpu_wr_ready=0 at count=4; push+pop in the same cycle keeps the count at 4; a 5th write is accepted only after the count drops to 3.
REQ-020 Reset mid-flight: 3 CPU entries queued, pulse rst -> count=0, frame_wr_en=0; no queued data ever appears on the frame outputs.
REQ-021 Pointer wrap: 10 CPU writes through a 4-deep FIFO with random XL traffic -> all 10 outputs in order, no loss or duplication.
